approx_adder_err_monitor: RTL and testbench

Sequential error-characterisation block that sits on the output side of the approximate adders (low_power_adder family). It receives the same operand/mask stream that drives an adder, together with the adder's approximate result. Over a programmed window of samples it accumulates the error count, the error-distance sum and the maximum error distance against the exact sum. Results hold stable for readout by the surrounding harness or a host.

---
 rtl/approx_adder_err_monitor.sv | 169 ++++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// Approximate-adder error monitor: error count, saturating ED sum and max ED over a sample window.
// Latency: beat to stats is 2 edges, done follows the last beat by 3 edges; in_ready is the only back-pressure and is low outside RUN.
module approx_adder_err_monitor #(
    parameter int WIDTH  = 4,
    parameter int MASK_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [MASK_W-1:0]  mask,
    input  logic [WIDTH-1:0]   approx_out,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   ed_sum,
    output logic [WIDTH:0]     ed_max,
    output logic [MASK_W-1:0]  last_mask
);

    localparam int SW = ((CNT_W > WIDTH + 1) ? CNT_W : WIDTH + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic               drain_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               clear;
    logic               last_beat;

    logic               s1_vld;
    logic [WIDTH-1:0]   s1_in1;
    logic [WIDTH-1:0]   s1_in2;
    logic [WIDTH-1:0]   s1_ap;
    logic [MASK_W-1:0]  s1_mask;

    logic [WIDTH:0]     exact;
    logic [WIDTH:0]     ap_ext;
    logic [WIDTH:0]     ed;
    logic [SW-1:0]      sum_ext;
    logic [CNT_W-1:0]   sum_sat;
    logic [CNT_W-1:0]   cnt_sat;

    assign last_beat = accept && ((cnt_q + CNT_W'(1)) == target_q);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                // An empty window never opens the input and drains straight away.
                in_ready = (target_q != '0);
                accept   = in_valid && in_ready;
                if (target_q == '0 || last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    clear   = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            drain_q  <= 1'b0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
            if (clear) begin
                target_q <= num_samples;
                cnt_q    <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_in1  <= '0;
            s1_in2  <= '0;
            s1_ap   <= '0;
            s1_mask <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_in1  <= in1;
                s1_in2  <= in2;
                s1_ap   <= approx_out;
                s1_mask <= mask;
            end
        end
    end

    // Carry-out is part of the exact sum, so a dropped carry shows up as ED.
    always_comb begin
        exact   = {1'b0, s1_in1} + {1'b0, s1_in2};
        ap_ext  = {1'b0, s1_ap};
        ed      = (exact >= ap_ext) ? (exact - ap_ext) : (ap_ext - exact);
        sum_ext = SW'(ed_sum) + SW'(ed);
        sum_sat = (sum_ext > SW'(CNT_MAX)) ? CNT_MAX : sum_ext[CNT_W-1:0];
        cnt_sat = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
            last_mask <= '0;
        end else if (clear) begin
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
            last_mask <= '0;
        end else if (s1_vld) begin
            if (ed != '0) begin
                err_count <= cnt_sat;
            end
            ed_sum    <= sum_sat;
            last_mask <= s1_mask;
            if (ed > ed_max) begin
                ed_max <= ed;
            end
        end
    end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench for approx_adder_err_monitor: default build plus a CNT_W=4 build for saturation.
module tb_approx_adder_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start4;
    logic [15:0] num_samples;
    logic [3:0]  ns4;
    logic        in_valid, in_valid4;
    logic [3:0]  in1, in2, approx_out;
    logic [2:0]  mask;

    logic        in_ready, busy, done;
    logic [15:0] err_count, ed_sum;
    logic [4:0]  ed_max;
    logic [2:0]  last_mask;

    logic        in_ready4, busy4, done4;
    logic [3:0]  err_count4, ed_sum4;
    logic [4:0]  ed_max4;
    logic [2:0]  last_mask4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    approx_adder_err_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .mask(mask), .approx_out(approx_out), .busy(busy), .done(done),
        .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max), .last_mask(last_mask)
    );

    approx_adder_err_monitor #(.WIDTH(4), .MASK_W(3), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .num_samples(ns4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in1(in1), .in2(in2),
        .mask(mask), .approx_out(approx_out), .busy(busy4), .done(done4),
        .err_count(err_count4), .ed_sum(ed_sum4), .ed_max(ed_max4), .last_mask(last_mask4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ap, input logic [2:0] m);
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        approx_out = ap;
        mask = m;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done4(input int budget);
        int k = 0;
        while (!done4 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done4) check("done4_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic seen_ready;
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; num_samples = '0; ns4 = '0;
        in_valid = 1'b0; in_valid4 = 1'b0; in1 = '0; in2 = '0; approx_out = '0; mask = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_count", err_count, 0);
        check("rst_ed_sum", ed_sum, 0);
        check("rst_ed_max", ed_max, 0);
        check("rst_last_mask", last_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-window after 3 of 8 beats.
        do_start(16'd8);
        check("a_in_ready", in_ready, 1);
        repeat (3) send(4'd10, 4'd12, 4'd6, 3'd5);
        in_valid = 1'b0;
        check("a_err_before_rst", err_count, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("a_rst_busy", busy, 0);
        check("a_rst_in_ready", in_ready, 0);
        check("a_rst_err_count", err_count, 0);
        check("a_rst_ed_sum", ed_sum, 0);
        check("a_rst_ed_max", ed_max, 0);
        check("a_rst_last_mask", last_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("a_idle_in_ready", in_ready, 0);

        // Window of 1: 10+12=22 against 6 -> ED 16; done 3 edges after acceptance.
        do_start(16'd1);
        check("b_in_ready", in_ready, 1);
        check("b_busy", busy, 1);
        send(4'b1010, 4'b1100, 4'b0110, 3'b111);
        in_valid = 1'b0;
        check("b_in_ready_drop", in_ready, 0);
        check("b_done_t1", done, 0);
        @(negedge clk);
        check("b_done_t2", done, 0);
        check("b_err_early", err_count, 1);
        @(negedge clk);
        check("b_done_t3", done, 1);
        check("b_busy_done", busy, 0);
        check("b_err_count", err_count, 1);
        check("b_ed_sum", ed_sum, 16);
        check("b_ed_max", ed_max, 16);
        check("b_last_mask", last_mask, 3'b111);

        // Window of 4, all exact.
        do_start(16'd4);
        check("c_cleared", err_count, 0);
        send(4'd3, 4'd4, 4'd7, 3'd1);
        send(4'd1, 4'd2, 4'd3, 3'd4);
        send(4'd0, 4'd0, 4'd0, 3'd6);
        send(4'd7, 4'd8, 4'd15, 3'd2);
        in_valid = 1'b0;
        wait_done(10);
        check("c_err_count", err_count, 0);
        check("c_ed_sum", ed_sum, 0);
        check("c_ed_max", ed_max, 0);
        check("c_last_mask", last_mask, 3'd2);

        // Window of 3 with in_valid toggling 1,0,1,0,1; EDs 2,0,5.
        do_start(16'd3);
        send(4'd1, 4'd1, 4'd0, 3'd3);
        idle();
        send(4'd3, 4'd4, 4'd7, 3'd0);
        idle();
        send(4'd5, 4'd5, 4'd15, 3'd6);
        in_valid = 1'b0;
        wait_done(10);
        check("d_err_count", err_count, 2);
        check("d_ed_sum", ed_sum, 7);
        check("d_ed_max", ed_max, 5);
        check("d_last_mask", last_mask, 3'd6);
        // Beats offered in DONE are not consumed.
        repeat (3) send(4'd15, 4'd15, 4'd0, 3'd1);
        in_valid = 1'b0;
        check("d_hold_err", err_count, 2);
        check("d_hold_sum", ed_sum, 7);
        check("d_hold_mask", last_mask, 3'd6);

        // Empty window: in_ready never rises, stats stay zero even with in_valid high.
        seen_ready = 1'b0;
        in_valid = 1'b1; in1 = 4'd15; in2 = 4'd15; approx_out = 4'd0; mask = 3'd7;
        do_start(16'd0);
        for (int k = 0; k < 10 && !done; k++) begin
            if (in_ready) seen_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("e_done", done, 1);
        check("e_seen_ready", seen_ready, 0);
        check("e_err_count", err_count, 0);
        check("e_ed_sum", ed_sum, 0);
        check("e_ed_max", ed_max, 0);

        // CNT_W=4: four back-to-back ED=16 beats saturate the sum at 15.
        start4 = 1'b1; ns4 = 4'd4;
        @(negedge clk);
        start4 = 1'b0;
        in_valid4 = 1'b1; in1 = 4'd10; in2 = 4'd12; approx_out = 4'd6; mask = 3'd4;
        repeat (4) @(negedge clk);
        in_valid4 = 1'b0;
        wait_done4(10);
        check("f_ed_sum_sat", ed_sum4, 15);
        check("f_err_count", err_count4, 4);
        check("f_ed_max", ed_max4, 16);
        start4 = 1'b1; ns4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        check("f_clr_err", err_count4, 0);
        check("f_clr_sum", ed_sum4, 0);
        check("f_clr_max", ed_max4, 0);
        in_valid4 = 1'b1; in1 = 4'd5; in2 = 4'd5; approx_out = 4'd15; mask = 3'd1;
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_done4(10);
        check("f_ed_sum2", ed_sum4, 5);
        check("f_last_mask", last_mask4, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
